// File: rtl/complex_matched_filter.sv
// rtl/complex_matched_filter.sv - complex matched filter with coefficient load, streaming, flush and |Re|+|Im| output
module complex_matched_filter #(
  parameter int TAPS        = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + 1 + $clog2(TAPS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          loadCoefficients,
  input  logic                          coeffValid,
  input  logic signed [COEFF_WIDTH-1:0] coeffInRe,
  input  logic signed [COEFF_WIDTH-1:0] coeffInIm,
  output logic                          coefficientsSetFlag,
  input  logic                          dataValid,
  input  logic signed [DATA_WIDTH-1:0]  dataInRe,
  input  logic signed [DATA_WIDTH-1:0]  dataInIm,
  input  logic                          stopDataLoadFlag,
  output logic signed [ACC_WIDTH-1:0]   dataOutRe,
  output logic signed [ACC_WIDTH-1:0]   dataOutIm,
  output logic        [ACC_WIDTH:0]     dataOutMag,
  output logic                          outValid,
  output logic                          busy
);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int CW     = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, LOAD_COEFF, FILTER, FLUSH} state_t;

  state_t                        state;
  logic [CW-1:0]                 count;
  logic signed [COEFF_WIDTH-1:0] c_re [TAPS];
  logic signed [COEFF_WIDTH-1:0] c_im [TAPS];
  logic signed [DATA_WIDTH-1:0]  x_re [TAPS];
  logic signed [DATA_WIDTH-1:0]  x_im [TAPS];
  logic signed [DATA_WIDTH-1:0]  nx_re [TAPS];
  logic signed [DATA_WIDTH-1:0]  nx_im [TAPS];
  logic signed [PROD_W-1:0]      p_re [TAPS];
  logic signed [PROD_W-1:0]      p_im [TAPS];
  logic                          p_valid;
  logic                          shift;
  logic signed [DATA_WIDTH-1:0]  in_re, in_im;
  logic signed [ACC_WIDTH-1:0]   sum_re, sum_im;
  logic        [ACC_WIDTH-1:0]   abs_re, abs_im;

  assign busy = (state != IDLE);

  // Products are taken from the post-shift delay line so the sum lands two edges after acceptance.
  always_comb begin
    shift = 1'b0;
    in_re = dataInRe;
    in_im = dataInIm;
    case (state)
      IDLE:   shift = dataValid && coefficientsSetFlag && !loadCoefficients;
      FILTER: shift = dataValid;
      FLUSH: begin
        shift = 1'b1;
        in_re = '0;
        in_im = '0;
      end
      default: shift = 1'b0;
    endcase
    nx_re[0] = in_re;
    nx_im[0] = in_im;
    for (int k = 1; k < TAPS; k++) begin
      nx_re[k] = x_re[k-1];
      nx_im[k] = x_im[k-1];
    end
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_re = sum_re + ACC_WIDTH'(p_re[k]);
      sum_im = sum_im + ACC_WIDTH'(p_im[k]);
    end
    abs_re = sum_re[ACC_WIDTH-1] ? ACC_WIDTH'(-sum_re) : ACC_WIDTH'(sum_re);
    abs_im = sum_im[ACC_WIDTH-1] ? ACC_WIDTH'(-sum_im) : ACC_WIDTH'(sum_im);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      count               <= '0;
      coefficientsSetFlag <= 1'b0;
      p_valid             <= 1'b0;
      outValid            <= 1'b0;
      dataOutRe           <= '0;
      dataOutIm           <= '0;
      dataOutMag          <= '0;
      for (int k = 0; k < TAPS; k++) begin
        c_re[k] <= '0;
        c_im[k] <= '0;
        x_re[k] <= '0;
        x_im[k] <= '0;
        p_re[k] <= '0;
        p_im[k] <= '0;
      end
    end else begin
      p_valid  <= shift;
      outValid <= p_valid;
      if (shift) begin
        for (int k = 0; k < TAPS; k++) begin
          p_re[k] <= PROD_W'(nx_re[k]) * PROD_W'(c_re[k]) - PROD_W'(nx_im[k]) * PROD_W'(c_im[k]);
          p_im[k] <= PROD_W'(nx_re[k]) * PROD_W'(c_im[k]) + PROD_W'(nx_im[k]) * PROD_W'(c_re[k]);
        end
      end
      if (p_valid) begin
        dataOutRe  <= sum_re;
        dataOutIm  <= sum_im;
        dataOutMag <= (ACC_WIDTH+1)'(abs_re) + (ACC_WIDTH+1)'(abs_im);
      end

      case (state)
        IDLE: begin
          if (loadCoefficients) begin
            state               <= LOAD_COEFF;
            coefficientsSetFlag <= 1'b0;
            count               <= '0;
          end else if (shift) begin
            state <= FILTER;
            for (int k = 0; k < TAPS; k++) begin
              x_re[k] <= nx_re[k];
              x_im[k] <= nx_im[k];
            end
          end
        end
        LOAD_COEFF: begin
          if (coeffValid) begin
            for (int k = 0; k < TAPS; k++) begin
              if (count == CW'(k)) begin
                c_re[k] <= coeffInRe;
                c_im[k] <= coeffInIm;
              end
            end
            count <= count + CW'(1);
            if (count == CW'(TAPS - 1)) begin
              coefficientsSetFlag <= 1'b1;
              state               <= IDLE;
              count               <= '0;
            end
          end
        end
        FILTER: begin
          if (shift) begin
            for (int k = 0; k < TAPS; k++) begin
              x_re[k] <= nx_re[k];
              x_im[k] <= nx_im[k];
            end
          end
          if (stopDataLoadFlag) begin
            state <= FLUSH;
            count <= '0;
          end
        end
        FLUSH: begin
          count <= count + CW'(1);
          // Last zero shift clears the line outright; its products are already captured.
          for (int k = 0; k < TAPS; k++) begin
            x_re[k] <= (count == CW'(TAPS - 2)) ? '0 : nx_re[k];
            x_im[k] <= (count == CW'(TAPS - 2)) ? '0 : nx_im[k];
          end
          if (count == CW'(TAPS - 2)) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
